// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between fetch and data ports.
// Data port has priority, bounded by a starvation counter for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              owner_o,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              pick_d;

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
    end
  end

  // Next-state: grant in IDLE, strobe in ISSUE, count latency, pulse ready
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    pick_d     = d_req_i &
                 ~(if_req_i & (starve_q == 4'(STARVE_MAX)));
    unique case (state_q)
      IDLE: begin
        if (if_req_i | d_req_i) begin
          owner_d  = pick_d;
          we_d     = pick_d & d_we_i;
          addr_d   = pick_d ? d_addr_i : if_addr_i;
          wdata_d  = pick_d ? d_wdata_i : '0;
          mem_en_d = 1'b1;
          mem_we_d = pick_d & d_we_i;
          state_d  = ISSUE;
          if (pick_d & if_req_i) begin
            if (starve_q < 4'(STARVE_MAX))
              starve_d = starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 4'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          // A dropped requester gets neither data nor a pulse
          if (owner_q) begin
            if (d_req_i) begin
              d_ready_d = 1'b1;
              if (!we_q)
                d_rdata_d = mem_rdata_i;
            end
          end else if (if_req_i) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_ready_o  = if_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign owner_o     = owner_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = d_req_i & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, queued
// expectations, and a negedge monitor checking memory strobes and readies.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ready_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'hBAD0_BAD0;
  logic        owner_o;
  logic        stall_if_o;
  logic        stall_mem_o;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ready_o(d_ready_o),
    .d_rdata_o(d_rdata_o), .mem_en_o(mem_en_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .owner_o(owner_o), .stall_if_o(stall_if_o),
    .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          own;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } rdy_exp_t;

  mem_exp_t mq[$];
  rdy_exp_t rq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Memory model: unwritten words read as addr ^ 0x5A5A0000
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_addr = '0;
  int          rd_cnt = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    mem_rdata_i = 32'hBAD0_BAD0;
    if (rst) begin
      rd_cnt = 0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) mem_rdata_i = rd_val(rd_addr);
      end
      if (mem_en_o) begin
        if (mem_we_o) begin
          mem[mem_addr_o] = mem_wdata_o;
        end else begin
          rd_addr = mem_addr_o;
          rd_cnt = LAT;
        end
      end
    end
  end

  task automatic pop_ready(input bit port, input logic [31:0] data);
    rdy_exp_t e;
    if (rq.size() == 0) begin
      bad(port ? "d_ready_unexp" : "if_ready_unexp");
    end else begin
      e = rq.pop_front();
      chk("ready_port", 32'(port), 32'(e.port));
      chk("rdata", data, e.data);
      chk("ready_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: pops an expectation whenever the DUT strobes or pulses
  always @(negedge clk) begin
    mem_exp_t me;
    if (!rst) begin
      if (mem_en_o) begin
        if (mq.size() == 0) begin
          bad("mem_en_unexp");
        end else begin
          me = mq.pop_front();
          chk("mem_owner", 32'(owner_o), 32'(me.own));
          chk("mem_we", 32'(mem_we_o), 32'(me.we));
          chk("mem_addr", mem_addr_o, me.addr);
          if (me.we) chk("mem_wdata", mem_wdata_o, me.wdata);
          chk("mem_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      if (if_ready_o && d_ready_o) bad("both_ready");
      if (if_ready_o) pop_ready(1'b0, if_rdata_o);
      if (d_ready_o) pop_ready(1'b1, d_rdata_o);
    end
  end

  // One request on one port, held until ready, stall checked every cycle
  task automatic run_req(input bit port, input bit we,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] exp_rd);
    int c;
    bit done;
    @(negedge clk);
    c = cyc;
    if (port) begin
      d_req_i = 1'b1; d_we_i = we;
      d_addr_i = addr; d_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    mq.push_back('{port, we, addr, wdata, c + 1});
    rq.push_back('{port, exp_rd, c + LAT + 2});
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (port ? d_ready_o : if_ready_o) begin
        chk("stall_at_ready",
            32'(port ? stall_mem_o : stall_if_o), 32'd0);
        done = 1'b1;
      end else begin
        chk("stall_busy",
            32'(port ? stall_mem_o : stall_if_o), 32'd1);
      end
    end
    if (!done) bad("ready_timeout");
    if (port) d_req_i = 1'b0;
    else if_req_i = 1'b0;
    #1;
    chk("stall_idle", 32'(port ? stall_mem_o : stall_if_o), 32'd0);
  endtask

  initial begin
    int c;
    bit got;
    mem[32'h10] = 32'h00A0_0093;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_ready", 32'(if_ready_o), 32'd0);
    chk("rst_d_ready", 32'(d_ready_o), 32'd0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    rst = 1'b0;

    // Fetch, store, load-back
    run_req(1'b0, 1'b0, 32'h10, 32'h0, 32'h00A0_0093);
    run_req(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0);
    chk("d_rdata_after_store", d_rdata_o, 32'h0);
    run_req(1'b1, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF);

    // Both ports held: D,D,D,I,D,D,D,I, one grant per LAT+3
    @(negedge clk);
    c = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h30;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
    for (int k = 0; k < 8; k++) begin
      bit p;
      p = !(k == 3 || k == 7);
      mq.push_back('{p, 1'b0, p ? 32'h20 : 32'h30, 32'h0,
                     c + 1 + 5 * k});
      rq.push_back('{p, p ? 32'h5A5A_0020 : 32'h5A5A_0030,
                     c + 4 + 5 * k});
    end
    repeat (39) @(negedge clk);
    #1;
    if_req_i = 1'b0; d_req_i = 1'b0;

    // Fetch dropped in WAIT; pending load granted next IDLE
    @(negedge clk);
    c = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    mq.push_back('{1'b0, 1'b0, 32'h40, 32'h0, c + 1});
    repeat (2) @(negedge clk);
    if_req_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h44;
    mq.push_back('{1'b1, 1'b0, 32'h44, 32'h0, c + 6});
    rq.push_back('{1'b1, 32'h5A5A_0044, c + 9});
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = d_ready_o;
    end
    if (!got) bad("drop_timeout");
    #1;
    d_req_i = 1'b0;
    chk("if_rdata_kept", if_rdata_o, 32'h5A5A_0030);

    // Reset in WAIT, then a fresh load
    @(negedge clk);
    c = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    mq.push_back('{1'b0, 1'b0, 32'h10, 32'h0, c + 1});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    if_req_i = 1'b0;
    #1;
    chk("wrst_mem_en", 32'(mem_en_o), 32'd0);
    chk("wrst_if_ready", 32'(if_ready_o), 32'd0);
    chk("wrst_owner", 32'(owner_o), 32'd0);
    chk("wrst_if_rdata", if_rdata_o, 32'd0);
    chk("wrst_d_rdata", d_rdata_o, 32'd0);
    chk("wrst_mem_addr", mem_addr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h5A5A_0020);

    repeat (6) @(negedge clk);
    #1;
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    chk("ready_queue_empty", 32'(rq.size()), 32'd0);
    chk("stall_if_quiet", 32'(stall_if_o), 32'd0);
    chk("stall_mem_quiet", 32'(stall_mem_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
